player_shot: RTL and testbench
==============================

Name: player_shot

Overview:
- Player projectile controller: launches one shot from the player's x-position, moves it upward once per frame, and tests it against a single enemy's bounding box.
- Sits directly upstream of the enemy ship block. Its hit_o drives that block's hit_i; its box inputs come from the enemy's left/right/top/bot position outputs.
- Only one shot may be in flight at a time. A cooldown period follows every hit or miss before the next shot can be fired.

Parameters:
- speed_p, 10'd4, pixels the shot moves up per frame_i pulse
- shot_w_p, 10'd2, shot width in pixels
- launch_y_p, 10'd440, shot top y-coordinate at launch
- cooldown_p, 8'd8, frame_i pulses spent in COOLDOWN before a new shot is allowed (must be ≥1)
- color_p, 12'hFF0, shot colour as {R,G,B} nibbles

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- frame_i  in  1  one-cycle pulse per processed frame
- fire_i  in  1  fire request (level; sampled only in IDLE)
- player_x_i  in  10  player left x-coordinate; latched at launch
- enemy_left_i  in  10  enemy left edge
- enemy_right_i  in  10  enemy right edge
- enemy_top_i  in  10  enemy vertical bound A
- enemy_bot_i  in  10  enemy vertical bound B (either ordering is accepted)
- enemy_dead_i  in  1  enemy is dead or idle; suppresses collision
- hit_o  out  1  one-cycle pulse on collision, to enemy hit_i
- shot_active_o  out  1  high while the shot is in flight
- shot_x_o  out  10  shot left x-coordinate
- shot_y_o  out  10  shot top y-coordinate
- shot_red_o / shot_green_o / shot_blue_o  out  4 each  color_p[11:8] / [7:4] / [3:0]

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; hit_o=0; shot_active_o=0; shot_x_o=0; shot_y_o=launch_y_p; cooldown counter=0. Reset asserted mid-flight or mid-cooldown aborts immediately to these values.
- States: IDLE, FLY, COOLDOWN. All outputs are registered except the colour outputs, which are constants.
- IDLE:
  - If fire_i=1 on a clock edge: latch shot_x_o=player_x_i and shot_y_o=launch_y_p, and go to FLY. shot_active_o is 1 from the next cycle.
  - Otherwise remain in IDLE.
- FLY, collision term (computed from current registers and inputs):
  - ymin=min(enemy_top_i,enemy_bot_i), ymax=max(enemy_top_i,enemy_bot_i).
  - overlap = (shot_x_o+shot_w_p-1 ≥ enemy_left_i) & (shot_x_o ≤ enemy_right_i) & (shot_y_o ≥ ymin) & (shot_y_o ≤ ymax).
  - All bounds are inclusive. The x+w sum uses 11-bit arithmetic so it cannot wrap.
- FLY, priority per cycle (highest first):
  1. overlap & ~enemy_dead_i: register hit_o=1 for exactly one cycle; go to COOLDOWN; shot_y_o holds. This applies even if frame_i=1 in the same cycle (collision wins over movement).
  2. frame_i & (shot_y_o < speed_p): miss at the top of the screen; go to COOLDOWN. shot_y_o is never decremented below 0 (no underflow wrap).
  3. frame_i: shot_y_o -= speed_p; remain in FLY.
  4. Otherwise hold.
- COOLDOWN:
  - On entry the counter loads 0, shot_active_o falls to 0, and hit_o returns to 0 on the following cycle.
  - Each frame_i increments the counter. When it reaches cooldown_p, go to IDLE and set shot_y_o=launch_y_p.
  - fire_i is ignored throughout COOLDOWN.
- At most one hit_o pulse is produced per shot. A fire_i held high re-fires on the first IDLE cycle after cooldown (auto-repeat is intentional).
- enemy_dead_i=1 lets the shot pass through the box and continue as a miss.
- shot_x_o is not clamped. The player block guarantees player_x_i ≤ 638-shot_w_p.

Test Plan:
- Reset mid-FLY (shot_y_o=300) → same cycle: shot_active_o=0, shot_y_o=440, hit_o=0; state IDLE.
- Fire with player_x_i=100, no enemy overlap, 120 frames → FLY. shot_y_o steps 440→436→…→0 (110 frames), then the next frame → COOLDOWN, no underflow. After 8 more frames → IDLE; hit_o never asserted.
- Fire at x=100; enemy box left=95, right=135, top=200, bot=190 → shot_y_o reaches 200 after 60 frames. hit_o=1 for exactly one cycle, then COOLDOWN; shot_y_o holds 200.
- Same box with enemy_dead_i=1 → no hit_o; shot passes through and exits as a miss.
- Edge inclusivity: shot_x=94 (right edge 95 = enemy_left) → hit. shot_x=136 → no hit. Box given with top=190, bot=200 (swapped) → hit still occurs.
- fire_i held high continuously → one shot per flight+cooldown cycle. fire_i pulses during COOLDOWN produce no launch. Overlap and frame_i in the same cycle → hit_o=1 and shot_y_o unchanged.

Source files
------------

// File: rtl/player_shot_if.sv
// Signal bundle between the player-shot controller and its surroundings.
// The master side drives frame/fire/player/enemy inputs. The slave side
// (the controller) drives hit, shot position and colour.
interface player_shot_if;
    logic       frame_i;
    logic       fire_i;
    logic [9:0] player_x_i;
    logic [9:0] enemy_left_i;
    logic [9:0] enemy_right_i;
    logic [9:0] enemy_top_i;
    logic [9:0] enemy_bot_i;
    logic       enemy_dead_i;

    logic       hit_o;
    logic       shot_active_o;
    logic [9:0] shot_x_o;
    logic [9:0] shot_y_o;
    logic [3:0] shot_red_o;
    logic [3:0] shot_green_o;
    logic [3:0] shot_blue_o;

    modport master (
        output frame_i, fire_i, player_x_i,
        output enemy_left_i, enemy_right_i, enemy_top_i, enemy_bot_i, enemy_dead_i,
        input  hit_o, shot_active_o, shot_x_o, shot_y_o,
        input  shot_red_o, shot_green_o, shot_blue_o
    );

    modport slave (
        input  frame_i, fire_i, player_x_i,
        input  enemy_left_i, enemy_right_i, enemy_top_i, enemy_bot_i, enemy_dead_i,
        output hit_o, shot_active_o, shot_x_o, shot_y_o,
        output shot_red_o, shot_green_o, shot_blue_o
    );
endinterface

// File: rtl/player_shot.sv
// Player projectile controller: one shot in flight at a time, moving up once
// per frame pulse, tested against a single enemy bounding box. Every hit or
// miss is followed by a cooldown measured in frame pulses.
module player_shot #(
    parameter logic [9:0]  speed_p    = 10'd4,
    parameter logic [9:0]  shot_w_p   = 10'd2,
    parameter logic [9:0]  launch_y_p = 10'd440,
    parameter logic [7:0]  cooldown_p = 8'd8,
    parameter logic [11:0] color_p    = 12'hFF0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    player_shot_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t      state_reg;
    logic        hit_reg;
    logic        active_reg;
    logic [9:0]  shot_x_reg;
    logic [9:0]  shot_y_reg;
    logic [7:0]  cool_cnt_reg;

    logic [9:0]  y_min;
    logic [9:0]  y_max;
    logic [10:0] shot_right;
    logic        overlap;
    logic        hit_now;
    logic        at_top;
    logic [7:0]  cool_cnt_next;

    // Collision term: vertical bounds may arrive in either order, and the
    // right edge uses 11 bits so x + w - 1 cannot wrap.
    always_comb begin
        y_min      = (bus.enemy_top_i <= bus.enemy_bot_i) ? bus.enemy_top_i : bus.enemy_bot_i;
        y_max      = (bus.enemy_top_i <= bus.enemy_bot_i) ? bus.enemy_bot_i : bus.enemy_top_i;
        shot_right = {1'b0, shot_x_reg} + {1'b0, shot_w_p} - 11'd1;
        overlap    = (shot_right >= {1'b0, bus.enemy_left_i})
                   & (shot_x_reg <= bus.enemy_right_i)
                   & (shot_y_reg >= y_min)
                   & (shot_y_reg <= y_max);
        hit_now    = overlap & ~bus.enemy_dead_i;
        // A further step would take the shot above row 0: treat as a miss.
        at_top     = (shot_y_reg < speed_p);
        cool_cnt_next = cool_cnt_reg + 8'd1;
    end

    // Shot state machine; all outputs are registered here.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg    <= IDLE;
            hit_reg      <= 1'b0;
            active_reg   <= 1'b0;
            shot_x_reg   <= 10'd0;
            shot_y_reg   <= launch_y_p;
            cool_cnt_reg <= 8'd0;
        end else begin
            // hit is a single-cycle pulse unless re-asserted below.
            hit_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.fire_i) begin
                        shot_x_reg <= bus.player_x_i;
                        shot_y_reg <= launch_y_p;
                        active_reg <= 1'b1;
                        state_reg  <= FLY;
                    end
                end
                FLY: begin
                    // Collision outranks movement, so a hit freezes shot_y.
                    if (hit_now) begin
                        hit_reg      <= 1'b1;
                        active_reg   <= 1'b0;
                        cool_cnt_reg <= 8'd0;
                        state_reg    <= COOLDOWN;
                    end else if (bus.frame_i && at_top) begin
                        active_reg   <= 1'b0;
                        cool_cnt_reg <= 8'd0;
                        state_reg    <= COOLDOWN;
                    end else if (bus.frame_i) begin
                        shot_y_reg <= shot_y_reg - speed_p;
                    end
                end
                COOLDOWN: begin
                    // fire is deliberately ignored here.
                    if (bus.frame_i) begin
                        cool_cnt_reg <= cool_cnt_next;
                        if (cool_cnt_next == cooldown_p) begin
                            shot_y_reg <= launch_y_p;
                            state_reg  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hit_o         = hit_reg;
    assign bus.shot_active_o = active_reg;
    assign bus.shot_x_o      = shot_x_reg;
    assign bus.shot_y_o      = shot_y_reg;
    assign bus.shot_red_o    = color_p[11:8];
    assign bus.shot_green_o  = color_p[7:4];
    assign bus.shot_blue_o   = color_p[3:0];

endmodule

// File: tb/tb_player_shot.sv
// Bench for player_shot: each fired shot pushes its expected outcome
// (hit, final y, x) into a queue; a monitor pops and compares whenever a
// flight ends. Reset and cooldown timing are checked directly.
module tb_player_shot;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    player_shot_if bus();

    player_shot dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic       hit;
        logic [9:0] y;
        logic [9:0] x;
    } rec_t;

    rec_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        tick();
        bus.frame_i = 1'b1;
        tick();
        bus.frame_i = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) frame_pulse();
    endtask

    task automatic push_exp(input logic hit, input logic [9:0] y, input logic [9:0] x);
        rec_t r;
        r.hit = hit;
        r.y   = y;
        r.x   = x;
        exp_q.push_back(r);
    endtask

    task automatic fire_shot(input logic [9:0] x);
        tick();
        bus.player_x_i = x;
        bus.fire_i     = 1'b1;
        tick();
        bus.fire_i     = 1'b0;
    endtask

    task automatic set_box(input logic [9:0] l, input logic [9:0] r,
                           input logic [9:0] t, input logic [9:0] b);
        bus.enemy_left_i  = l;
        bus.enemy_right_i = r;
        bus.enemy_top_i   = t;
        bus.enemy_bot_i   = b;
    endtask

    // Monitor: a flight ends when shot_active falls. The record is compared one
    // cycle later so that hit_o must already have dropped (one-cycle pulse).
    logic       prev_active = 1'b0;
    bit         pending     = 1'b0;
    logic       fall_hit;
    logic [9:0] fall_y;
    logic [9:0] fall_x;
    int         flight_hits = 0;
    int         fall_flight_hits = 0;

    initial begin
        rec_t act;
        rec_t req;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_active = 1'b0;
                pending     = 1'b0;
                flight_hits = 0;
            end else begin
                if (pending) begin
                    pending = 1'b0;
                    act.hit = fall_hit & ~bus.hit_o & (fall_flight_hits == 0);
                    act.y   = fall_y;
                    act.x   = fall_x;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL shot_end: unexpected end hit=%0d y=%0d x=%0d, required no shot",
                                 act.hit, act.y, act.x);
                    end else begin
                        req = exp_q.pop_front();
                        if (act !== req)begin
                            miscompares++;
                            $display("FAIL shot_end: got hit=%0d y=%0d x=%0d, required hit=%0d y=%0d x=%0d",
                                     act.hit, act.y, act.x, req.hit, req.y, req.x);
                        end else begin
                            $display("ok   shot_end: hit=%0d y=%0d x=%0d", act.hit, act.y, act.x);
                        end
                    end
                end
                if (bus.shot_active_o && !prev_active)
                    flight_hits = 0;
                if (bus.shot_active_o && bus.hit_o)
                    flight_hits++;
                if (prev_active && !bus.shot_active_o) begin
                    pending          = 1'b1;
                    fall_hit         = bus.hit_o;
                    fall_y           = bus.shot_y_o;
                    fall_x           = bus.shot_x_o;
                    fall_flight_hits = flight_hits;
                end
                prev_active = bus.shot_active_o;
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.frame_i      = 1'b0;
        bus.fire_i       = 1'b0;
        bus.player_x_i   = 10'd0;
        bus.enemy_dead_i = 1'b0;
        set_box(10'd500, 10'd520, 10'd10, 10'd20);
        #1;
        check("rst_active", {31'd0, bus.shot_active_o}, 32'd0);
        check("rst_y", {22'd0, bus.shot_y_o}, 32'd440);
        check("rst_hit", {31'd0, bus.hit_o}, 32'd0);
        check("rst_x", {22'd0, bus.shot_x_o}, 32'd0);
        check("color", {20'd0, bus.shot_red_o, bus.shot_green_o, bus.shot_blue_o}, 32'hFF0);
        tick();
        tick();
        rst = 1'b0;

        // Reset in mid-flight aborts at once (asynchronous).
        fire_shot(10'd100);
        frames(35);
        check("fly_y300", {22'd0, bus.shot_y_o}, 32'd300);
        check("fly_active", {31'd0, bus.shot_active_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_active", {31'd0, bus.shot_active_o}, 32'd0);
        check("midrst_y", {22'd0, bus.shot_y_o}, 32'd440);
        check("midrst_hit", {31'd0, bus.hit_o}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Clean miss: 110 frames reach y=0, the next one ends the flight.
        push_exp(1'b0, 10'd0, 10'd100);
        fire_shot(10'd100);
        frames(110);
        check("miss_y0", {22'd0, bus.shot_y_o}, 32'd0);
        check("miss_still_active", {31'd0, bus.shot_active_o}, 32'd1);
        frame_pulse();
        tick();
        check("miss_inactive", {31'd0, bus.shot_active_o}, 32'd0);
        check("miss_no_underflow", {22'd0, bus.shot_y_o}, 32'd0);
        frames(7);
        check("cool7_y_held", {22'd0, bus.shot_y_o}, 32'd0);
        frame_pulse();
        check("cool8_y_reload", {22'd0, bus.shot_y_o}, 32'd440);

        // Hit inside box at y=200 after 60 frames.
        set_box(10'd95, 10'd135, 10'd200, 10'd190);
        push_exp(1'b1, 10'd200, 10'd100);
        fire_shot(10'd100);
        frames(60);
        repeat (3) tick();
        check("hit_y_hold", {22'd0, bus.shot_y_o}, 32'd200);
        check("hit_inactive", {31'd0, bus.shot_active_o}, 32'd0);
        frames(8);

        // Dead enemy: the shot passes through and misses.
        bus.enemy_dead_i = 1'b1;
        push_exp(1'b0, 10'd0, 10'd100);
        fire_shot(10'd100);
        frames(111);
        frames(8);
        bus.enemy_dead_i = 1'b0;

        // Left-edge inclusivity with swapped bounds; frame and overlap coincide.
        set_box(10'd95, 10'd135, 10'd190, 10'd200);
        push_exp(1'b1, 10'd200, 10'd94);
        fire_shot(10'd94);
        frames(59);
        tick();
        bus.frame_i = 1'b1;
        tick();
        tick();
        bus.frame_i = 1'b0;
        check("same_cycle_y", {22'd0, bus.shot_y_o}, 32'd200);
        frames(8);

        // Just right of the box: no hit.
        push_exp(1'b0, 10'd0, 10'd136);
        fire_shot(10'd136);
        frames(111);
        frames(8);

        // Held fire auto-repeats only after the full cooldown.
        set_box(10'd500, 10'd520, 10'd10, 10'd20);
        bus.player_x_i = 10'd200;
        push_exp(1'b0, 10'd0, 10'd200);
        tick();
        bus.fire_i = 1'b1;
        tick();
        frames(111);
        frames(7);
        check("no_early_refire", {31'd0, bus.shot_active_o}, 32'd0);
        push_exp(1'b0, 10'd0, 10'd200);
        frame_pulse();
        tick();
        check("auto_refire", {31'd0, bus.shot_active_o}, 32'd1);
        check("refire_y", {22'd0, bus.shot_y_o}, 32'd440);
        bus.fire_i = 1'b0;
        frames(111);

        // Fire pulses during cooldown must not launch.
        repeat (7) begin
            frame_pulse();
            tick();
            bus.fire_i = 1'b1;
            tick();
            bus.fire_i = 1'b0;
        end
        frame_pulse();
        repeat (3) tick();
        check("no_fire_in_cool", {31'd0, bus.shot_active_o}, 32'd0);
        check("idle_y", {22'd0, bus.shot_y_o}, 32'd440);

        repeat (5) tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
